// File: rtl/hist_pkg.sv
// Shared types and defaults for the histogram scheduler and builder.
// Pass encoding and frame geometry defaults live here so both sides agree.
package hist_pkg;

  localparam int NP_DEF       = 16;
  localparam int PIXELS_DEF   = 4;
  localparam int DATA_NUM_DEF = 4;
  localparam int ACQ_NUM_DEF  = 8;
  localparam int DRAIN_DEF    = 3;

  localparam logic PASS_COARSE = 1'b0;
  localparam logic PASS_FINE   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COARSE,
    ST_DRAIN_C,
    ST_FINE,
    ST_DRAIN_F,
    ST_DONE
  } hist_state_e;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hist_pass_scheduler_if.sv
// TDC timestamp stream in, histogram-builder write port out.
// master = scheduler side, slave = front end / builder side.
interface hist_pass_scheduler_if
  import hist_pkg::*;
#(
  parameter int NP     = NP_DEF,
  parameter int PIXELS = PIXELS_DEF
);
  localparam int PW = cnt_w(PIXELS);

  logic          ts_valid;
  logic [NP-1:0] ts_data;
  logic          ts_ready;

  logic          hb_wr_en;
  logic [NP-1:0] hb_data;
  logic [PW-1:0] hb_pixel;
  logic          hb_pass;
  logic          hb_clear;

  modport master (
    input  ts_valid, ts_data,
    output ts_ready, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clear
  );

  modport slave (
    output ts_valid, ts_data,
    input  ts_ready, hb_wr_en, hb_data, hb_pixel, hb_pass, hb_clear
  );
endinterface

// File: rtl/hist_frame_counter.sv
// Cascaded timestamp/pixel/acquisition counters for one pass; pass_last flags the final slot.
// Advances one slot per inc, zero latency on pass_last, clr has priority over inc.
module hist_frame_counter
  import hist_pkg::*;
#(
  parameter int PIXELS   = PIXELS_DEF,
  parameter int DATA_NUM = DATA_NUM_DEF,
  parameter int ACQ_NUM  = ACQ_NUM_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     inc,
  output logic [cnt_w(PIXELS)-1:0] pix_cnt,
  output logic                     pass_last
);
  localparam int IW = cnt_w(DATA_NUM);
  localparam int PW = cnt_w(PIXELS);
  localparam int AW = cnt_w(ACQ_NUM);

  localparam logic [IW-1:0] IN_MAX  = IW'(DATA_NUM - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(PIXELS - 1);
  localparam logic [AW-1:0] ACQ_MAX = AW'(ACQ_NUM - 1);

  logic [IW-1:0] in_cnt;
  logic [AW-1:0] acq_cnt;

  assign pass_last = (in_cnt == IN_MAX) && (pix_cnt == PIX_MAX) && (acq_cnt == ACQ_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt  <= '0;
      pix_cnt <= '0;
      acq_cnt <= '0;
    end else if (clr) begin
      in_cnt  <= '0;
      pix_cnt <= '0;
      acq_cnt <= '0;
    end else if (inc) begin
      if (in_cnt == IN_MAX) begin
        in_cnt <= '0;
        if (pix_cnt == PIX_MAX) begin
          pix_cnt <= '0;
          acq_cnt <= (acq_cnt == ACQ_MAX) ? '0 : acq_cnt + AW'(1);
        end else begin
          pix_cnt <= pix_cnt + PW'(1);
        end
      end else begin
        in_cnt <= in_cnt + IW'(1);
      end
    end
  end
endmodule

// File: rtl/hist_pass_scheduler.sv
// Runs one depth frame through the histogram builder as a coarse pass then a fine pass.
// Writes land 1 cycle after each handshake; ts_ready is state-only, low outside the passes.
module hist_pass_scheduler
  import hist_pkg::*;
#(
  parameter int PIXELS       = PIXELS_DEF,
  parameter int DATA_NUM     = DATA_NUM_DEF,
  parameter int ACQ_NUM      = ACQ_NUM_DEF,
  parameter int DRAIN_CYCLES = DRAIN_DEF
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        start,
  hist_pass_scheduler_if.master       bus,
  output logic                        coarse_done,
  output logic                        frame_done,
  output logic                        busy,
  output logic [15:0]                 frame_cnt
);
  localparam int PW = cnt_w(PIXELS);
  localparam int DW = cnt_w(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  hist_state_e   state;
  logic [DW-1:0] drain_cnt;
  logic          hs;
  logic          pass_last;
  logic [PW-1:0] pix_cnt;

  assign bus.ts_ready = (state == ST_COARSE) || (state == ST_FINE);
  assign hs           = bus.ts_valid && bus.ts_ready;

  hist_frame_counter #(
    .PIXELS   (PIXELS),
    .DATA_NUM (DATA_NUM),
    .ACQ_NUM  (ACQ_NUM)
  ) u_cnt (
    .clk       (clk),
    .rst       (res),
    .clr       (state == ST_CLEAR),
    .inc       (hs),
    .pix_cnt   (pix_cnt),
    .pass_last (pass_last)
  );

  // coarse_done/frame_done are registered on the last drain cycle, so they
  // trail the final write of the pass by exactly DRAIN_CYCLES cycles.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state        <= ST_IDLE;
      drain_cnt    <= '0;
      bus.hb_wr_en <= 1'b0;
      bus.hb_data  <= '0;
      bus.hb_pixel <= '0;
      bus.hb_pass  <= PASS_COARSE;
      bus.hb_clear <= 1'b0;
      coarse_done  <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      bus.hb_wr_en <= hs;
      if (hs) begin
        bus.hb_data  <= bus.ts_data;
        bus.hb_pixel <= pix_cnt;
        bus.hb_pass  <= (state == ST_FINE) ? PASS_FINE : PASS_COARSE;
      end
      bus.hb_clear <= 1'b0;
      coarse_done  <= 1'b0;
      frame_done   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_CLEAR;
            bus.hb_clear <= 1'b1;
            busy         <= 1'b1;
          end
        end
        ST_CLEAR: state <= ST_COARSE;
        ST_COARSE: begin
          if (hs && pass_last) begin
            state     <= ST_DRAIN_C;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN_C: begin
          if (drain_cnt == DRAIN_LAST) begin
            state       <= ST_FINE;
            coarse_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_FINE: begin
          if (hs && pass_last) begin
            state     <= ST_DRAIN_F;
            drain_cnt <= '0;
          end
        end
        ST_DRAIN_F: begin
          if (drain_cnt == DRAIN_LAST) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hist_pass_scheduler.sv
// Directed bench for hist_pass_scheduler: full frames, random gaps, ignored start, mid-frame reset, frame_cnt wrap.
module tb_hist_pass_scheduler;
  import hist_pkg::*;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        start = 1'b0;
  logic        coarse_done, frame_done, busy;
  logic [15:0] frame_cnt;

  hist_pass_scheduler_if #(.NP(16), .PIXELS(4)) bus ();

  hist_pass_scheduler dut (
    .clk         (clk),
    .res         (res),
    .start       (start),
    .bus         (bus),
    .coarse_done (coarse_done),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Upstream source: holds data until accepted, optionally with 50% valid gaps.
  logic        feed_en = 1'b0;
  logic        rand_mode = 1'b0;
  logic        fhs;
  logic [15:0] next_dat = 16'hFFF0;
  initial begin
    bus.ts_valid = 1'b0;
    bus.ts_data  = '0;
    forever begin
      @(negedge clk);
      fhs = bus.ts_valid && bus.ts_ready && !res;
      @(posedge clk);
      #1;
      if (fhs) next_dat = next_dat + 16'd1;
      bus.ts_valid = feed_en && (!rand_mode || ($urandom_range(0, 1) == 1));
      bus.ts_data  = next_dat;
    end
  end

  // Observer: reference queue of accepted data plus per-frame write bookkeeping.
  logic [15:0] q[$];
  logic [15:0] d;
  logic        ep;
  logic        prev_hs = 1'b0;
  int k = 0, cw_n = 0, fw_n = 0, lastc = 0, lastf = 0;
  int cd_cyc = 0, fd_cyc = 0, cd_n = 0, fd_n = 0;
  int lat_err = 0, ord_err = 0, pix_err = 0;
  bit rdy_hist [0:16383];
  initial begin
    forever begin
      @(negedge clk);
      if (res) begin
        q.delete();
        prev_hs = 1'b0;
      end else begin
        if (bus.hb_wr_en) begin
          if (!prev_hs || q.size() == 0) lat_err++;
          else begin
            d = q.pop_front();
            if (d !== bus.hb_data) ord_err++;
          end
          ep = (k >= 128) ? PASS_FINE : PASS_COARSE;
          if (bus.hb_pass !== ep || bus.hb_pixel !== 2'((k / 4) % 4)) pix_err++;
          if (k < 128) cw_n++; else fw_n++;
          if (k == 127) lastc = cyc;
          if (k == 255) lastf = cyc;
          k++;
        end else if (prev_hs) begin
          lat_err++;
        end
        if (bus.hb_clear) begin
          k = 0; cw_n = 0; fw_n = 0;
        end
        if (coarse_done) begin cd_cyc = cyc; cd_n++; end
        if (frame_done)  begin fd_cyc = cyc; fd_n++; end
        if (cyc < 16384) rdy_hist[cyc] = bus.ts_ready;
        prev_hs = bus.ts_valid && bus.ts_ready;
        if (prev_hs) q.push_back(bus.ts_data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_fd(input string tag, input int n0);
    int t = 0;
    while (fd_n == n0 && t < 3000) begin
      step(1);
      t++;
    end
    chk(tag, fd_n - n0, 1);
  endtask

  task automatic wait_k(input string tag, input int kmin);
    int t = 0;
    while (k < kmin && t < 3000) begin
      step(1);
      t++;
    end
    chk(tag, k >= kmin, 1);
  endtask

  int n0;

  initial begin
    // Reset state
    step(3);
    chk("rst_ts_ready", bus.ts_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_hb_wr_en", bus.hb_wr_en, 0);
    chk("rst_hb_clear", bus.hb_clear, 0);
    chk("rst_coarse_done", coarse_done, 0);
    chk("rst_frame_done", frame_done, 0);
    res = 1'b0;
    feed_en = 1'b1;
    step(2);
    chk("idle_no_ready", bus.ts_ready, 0);

    // Frame A: valid held high
    n0 = fd_n;
    pulse_start();
    chk("a_busy_after_start", busy, 1);
    chk("a_clear_cycle1", bus.hb_clear, 1);
    chk("a_ready_in_clear", bus.ts_ready, 0);
    step(1);
    chk("a_ready_cycle2", bus.ts_ready, 1);
    chk("a_clear_one_cycle", bus.hb_clear, 0);
    wait_fd("a_frame_done", n0);
    chk("a_coarse_writes", cw_n, 128);
    chk("a_fine_writes", fw_n, 128);
    chk("a_coarse_done_gap", cd_cyc - lastc, 3);
    chk("a_frame_done_gap", fd_cyc - lastf, 3);
    chk("a_drain_c_ready", {rdy_hist[lastc], rdy_hist[lastc+1], rdy_hist[lastc+2]}, 0);
    chk("a_done_ready", rdy_hist[fd_cyc], 0);
    chk("a_fine_ready", rdy_hist[cd_cyc], 1);
    chk("a_frame_cnt", frame_cnt, 1);
    chk("a_busy_low", busy, 0);
    chk("a_coarse_done_cnt", cd_n, 1);

    // Frame B: 50% valid gaps
    rand_mode = 1'b1;
    n0 = fd_n;
    pulse_start();
    wait_fd("b_frame_done", n0);
    rand_mode = 1'b0;
    chk("b_coarse_writes", cw_n, 128);
    chk("b_fine_writes", fw_n, 128);
    chk("b_frame_cnt", frame_cnt, 2);
    chk("b_order_err", ord_err, 0);
    chk("b_latency_err", lat_err, 0);

    // Frame C: start pulsed during FINE is ignored
    n0 = fd_n;
    pulse_start();
    wait_k("c_reach_fine", 140);
    pulse_start();
    wait_fd("c_frame_done", n0);
    chk("c_frame_cnt", frame_cnt, 3);
    step(4);
    chk("c_no_restart", busy, 0);
    chk("c_single_done", fd_n - n0, 1);

    // Mid-frame reset after ~70 coarse handshakes
    pulse_start();
    wait_k("r_reach_70", 70);
    n0 = fd_n;
    res = 1'b1;
    #1;
    chk("r_hb_wr_en", bus.hb_wr_en, 0);
    chk("r_ts_ready", bus.ts_ready, 0);
    chk("r_busy", busy, 0);
    chk("r_frame_cnt", frame_cnt, 0);
    step(3);
    res = 1'b0;
    step(2);
    chk("r_no_frame_done", fd_n - n0, 0);
    chk("r_idle_after", busy, 0);
    pulse_start();
    wait_fd("r_frame_done", n0);
    chk("r_coarse_writes", cw_n, 128);
    chk("r_fine_writes", fw_n, 128);
    chk("r_frame_cnt", frame_cnt, 1);

    // frame_cnt wrap from 0xFFFF
    force dut.frame_cnt = 16'hFFFF;
    step(1);
    release dut.frame_cnt;
    step(1);
    chk("w_preload", frame_cnt, 16'hFFFF);
    n0 = fd_n;
    pulse_start();
    wait_fd("w_frame_done", n0);
    chk("w_frame_cnt_wrap", frame_cnt, 0);

    chk("tot_order_err", ord_err, 0);
    chk("tot_latency_err", lat_err, 0);
    chk("tot_pixel_pass_err", pix_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
